// File: rtl/multicycle_seq.sv
// Multi-cycle control sequencer for the RV32I core: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB so fetch and data access can share one memory port.
module multicycle_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        br_less,
    input  logic        br_equal,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_addr_sel,
    output logic        mem_wren,
    output logic        ir_wren,
    output logic        ld_wren,
    output logic        pc_wren,
    output logic        br_sel,
    output logic        br_unsigned,
    output logic        rd_wren,
    output logic        op_a_sel,
    output logic        op_b_sel,
    output logic [3:0]  alu_op,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_OP     = 5'b01100;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    state_t state_reg;
    state_t state_next;

    logic [4:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
    logic       legal;
    logic       taken;
    logic       sel_a;
    logic       sel_b;
    logic [3:0] sel_alu;
    logic       unused_instr;

    assign opcode       = instr[6:2];
    assign funct3       = instr[14:12];
    assign alt          = instr[30];
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_jump   = (opcode == OPC_JAL) || (opcode == OPC_JALR);

    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt_bit,
                                              input logic allow_sub);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (allow_sub && alt_bit) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt_bit ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Opcode legality, operand selects and ALU op are pure functions of the IR.
    always_comb begin
        legal   = 1'b0;
        sel_a   = 1'b0;
        sel_b   = 1'b1;
        sel_alu = ALU_ADD;
        case (opcode)
            OPC_LUI:    begin legal = 1'b1; sel_alu = ALU_PASS; end
            OPC_AUIPC:  begin legal = 1'b1; sel_a = 1'b1; end
            OPC_JAL:    begin legal = 1'b1; sel_a = 1'b1; end
            OPC_JALR:   legal = 1'b1;
            OPC_BRANCH: begin legal = (funct3[2:1] != 2'b01); sel_a = 1'b1; end
            OPC_LOAD:   legal = (funct3 == 3'b010);
            OPC_STORE:  legal = (funct3 == 3'b010);
            OPC_OPIMM:  begin legal = 1'b1; sel_alu = alu_decode(funct3, alt, 1'b0); end
            OPC_OP:     begin legal = 1'b1; sel_b = 1'b0; sel_alu = alu_decode(funct3, alt, 1'b1); end
            default:    legal = 1'b0;
        endcase
        if (instr[1:0] != 2'b11) begin
            legal = 1'b0;
        end
    end

    always_comb begin
        case (funct3)
            3'b000:         taken = br_equal;
            3'b001:         taken = !br_equal;
            3'b100, 3'b110: taken = br_less;
            3'b101, 3'b111: taken = !br_less;
            default:        taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_next = legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (is_branch) begin
                    state_next = S_FETCH;
                end else if (is_load || is_store) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_next = is_load ? S_WB : S_FETCH;
                end
            end
            S_WB:     state_next = S_FETCH;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_addr_sel = 1'b0;
        mem_wren     = 1'b0;
        ir_wren      = 1'b0;
        ld_wren      = 1'b0;
        pc_wren      = 1'b0;
        br_sel       = 1'b0;
        br_unsigned  = 1'b0;
        rd_wren      = 1'b0;
        op_a_sel     = 1'b0;
        op_b_sel     = 1'b0;
        alu_op       = 4'd0;
        wb_sel       = 2'd0;
        retire       = 1'b0;
        illegal      = 1'b0;
        // ALU selects stay up through MEM and WB so the address / result hold steady.
        if (state_reg == S_EXEC || state_reg == S_MEM || state_reg == S_WB) begin
            op_a_sel = sel_a;
            op_b_sel = sel_b;
            alu_op   = sel_alu;
        end
        case (state_reg)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_wren = mem_ready;
            end
            S_EXEC: begin
                if (is_branch) begin
                    br_unsigned = (funct3[2:1] == 2'b11);
                    br_sel      = taken;
                    pc_wren     = 1'b1;
                    retire      = 1'b1;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_wren     = is_store;
                if (mem_ready) begin
                    ld_wren = is_load;
                    pc_wren = is_store;
                    retire  = is_store;
                end
            end
            S_WB: begin
                rd_wren = 1'b1;
                pc_wren = 1'b1;
                retire  = 1'b1;
                br_sel  = is_jump;
                wb_sel  = is_load ? 2'd1 : (is_jump ? 2'd2 : 2'd0);
            end
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed bench for multicycle_seq: walks instructions cycle by cycle and compares
// the full output vector against hand-computed values.
module tb_multicycle_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        br_less;
    logic        br_equal;
    logic        mem_ready;
    logic        mem_req, mem_addr_sel, mem_wren, ir_wren, ld_wren, pc_wren;
    logic        br_sel, br_unsigned, rd_wren, op_a_sel, op_b_sel, retire, illegal;
    logic [3:0]  alu_op;
    logic [1:0]  wb_sel;

    int checks = 0;
    int errors = 0;

    multicycle_seq dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .br_less      (br_less),
        .br_equal     (br_equal),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_addr_sel (mem_addr_sel),
        .mem_wren     (mem_wren),
        .ir_wren      (ir_wren),
        .ld_wren      (ld_wren),
        .pc_wren      (pc_wren),
        .br_sel       (br_sel),
        .br_unsigned  (br_unsigned),
        .rd_wren      (rd_wren),
        .op_a_sel     (op_a_sel),
        .op_b_sel     (op_b_sel),
        .alu_op       (alu_op),
        .wb_sel       (wb_sel),
        .retire       (retire),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    // {mem_req, mem_addr_sel, mem_wren, ir_wren, ld_wren, pc_wren, br_sel, br_unsigned,
    //  rd_wren, op_a_sel, op_b_sel, alu_op[3:0], wb_sel[1:0], retire, illegal}
    logic [18:0] obs;
    assign obs = {mem_req, mem_addr_sel, mem_wren, ir_wren, ld_wren, pc_wren, br_sel,
                  br_unsigned, rd_wren, op_a_sel, op_b_sel, alu_op, wb_sel, retire, illegal};

    function automatic logic [18:0] v(input logic mreq, masel, mwr, irw, ldw, pcw, bsel, bu,
                                      rdw, asel, bop, input logic [3:0] alu,
                                      input logic [1:0] wb, input logic ret, ill);
        return {mreq, masel, mwr, irw, ldw, pcw, bsel, bu, rdw, asel, bop, alu, wb, ret, ill};
    endfunction

    task automatic chk(input string tag, input logic [18:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Called just after a negedge: apply mem_ready, check this cycle, advance one cycle.
    task automatic cyc(input logic rdy, input logic [18:0] expv, input string tag);
        mem_ready = rdy;
        #1;
        chk(tag, expv);
        $display("step %-14s instr=%h ready=%b obs=%b", tag, instr, rdy, obs);
        @(negedge clk);
    endtask

    logic [18:0] zero_v, f_wait, f_go, dec_v;

    initial begin
        zero_v = '0;
        f_wait = v(1,0,0,0,0,0,0,0,0,0,0,4'd0,2'd0,0,0);
        f_go   = v(1,0,0,1,0,0,0,0,0,0,0,4'd0,2'd0,0,0);
        dec_v  = zero_v;

        rst = 1'b1; instr = 32'h0; br_less = 1'b0; br_equal = 1'b0; mem_ready = 1'b1;
        @(negedge clk); #1;
        chk("reset_hold", zero_v);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        cyc(1'b1, zero_v, "idle");

        // addi x1, x0, 5
        instr = 32'h00500093;
        cyc(1'b1, f_go,  "addi_fetch");
        cyc(1'b1, dec_v, "addi_decode");
        cyc(1'b1, v(0,0,0,0,0,0,0,0,0,0,1,4'd0,2'd0,0,0), "addi_exec");
        cyc(1'b1, v(0,0,0,0,0,1,0,0,1,0,1,4'd0,2'd0,1,0), "addi_wb");

        // lw x2, 0(x1) with two wait cycles in FETCH and in MEM
        instr = 32'h0000A103;
        cyc(1'b0, f_wait, "lw_fetch_w1");
        cyc(1'b0, f_wait, "lw_fetch_w2");
        cyc(1'b1, f_go,   "lw_fetch");
        cyc(1'b1, dec_v,  "lw_decode");
        cyc(1'b1, v(0,0,0,0,0,0,0,0,0,0,1,4'd0,2'd0,0,0), "lw_exec");
        cyc(1'b0, v(1,1,0,0,0,0,0,0,0,0,1,4'd0,2'd0,0,0), "lw_mem_w1");
        cyc(1'b0, v(1,1,0,0,0,0,0,0,0,0,1,4'd0,2'd0,0,0), "lw_mem_w2");
        cyc(1'b1, v(1,1,0,0,1,0,0,0,0,0,1,4'd0,2'd0,0,0), "lw_mem");
        cyc(1'b1, v(0,0,0,0,0,1,0,0,1,0,1,4'd0,2'd1,1,0), "lw_wb");

        // sw x2, 4(x1) with one MEM wait cycle
        instr = 32'h0020A223;
        cyc(1'b1, f_go,  "sw_fetch");
        cyc(1'b1, dec_v, "sw_decode");
        cyc(1'b1, v(0,0,0,0,0,0,0,0,0,0,1,4'd0,2'd0,0,0), "sw_exec");
        cyc(1'b0, v(1,1,1,0,0,0,0,0,0,0,1,4'd0,2'd0,0,0), "sw_mem_w");
        cyc(1'b1, v(1,1,1,0,0,1,0,0,0,0,1,4'd0,2'd0,1,0), "sw_mem");

        // beq taken, then not taken
        instr = 32'h00000463; br_equal = 1'b1;
        cyc(1'b1, f_go,  "beq_t_fetch");
        cyc(1'b1, dec_v, "beq_t_decode");
        cyc(1'b1, v(0,0,0,0,0,1,1,0,0,1,1,4'd0,2'd0,1,0), "beq_t_exec");
        br_equal = 1'b0;
        cyc(1'b1, f_go,  "beq_n_fetch");
        cyc(1'b1, dec_v, "beq_n_decode");
        cyc(1'b1, v(0,0,0,0,0,1,0,0,0,1,1,4'd0,2'd0,1,0), "beq_n_exec");

        // bltu taken (unsigned), bge not taken (signed)
        instr = 32'h00006463; br_less = 1'b1;
        cyc(1'b1, f_go,  "bltu_fetch");
        cyc(1'b1, dec_v, "bltu_decode");
        cyc(1'b1, v(0,0,0,0,0,1,1,1,0,1,1,4'd0,2'd0,1,0), "bltu_exec");
        instr = 32'h00005463;
        cyc(1'b1, f_go,  "bge_fetch");
        cyc(1'b1, dec_v, "bge_decode");
        cyc(1'b1, v(0,0,0,0,0,1,0,0,0,1,1,4'd0,2'd0,1,0), "bge_exec");
        br_less = 1'b0;

        // sub x1, x2, x3
        instr = 32'h403100B3;
        cyc(1'b1, f_go,  "sub_fetch");
        cyc(1'b1, dec_v, "sub_decode");
        cyc(1'b1, v(0,0,0,0,0,0,0,0,0,0,0,4'd1,2'd0,0,0), "sub_exec");
        cyc(1'b1, v(0,0,0,0,0,1,0,0,1,0,0,4'd1,2'd0,1,0), "sub_wb");

        // srai x1, x1, 3
        instr = 32'h4030D093;
        cyc(1'b1, f_go,  "srai_fetch");
        cyc(1'b1, dec_v, "srai_decode");
        cyc(1'b1, v(0,0,0,0,0,0,0,0,0,0,1,4'd9,2'd0,0,0), "srai_exec");
        cyc(1'b1, v(0,0,0,0,0,1,0,0,1,0,1,4'd9,2'd0,1,0), "srai_wb");

        // lui x1, 0x12345
        instr = 32'h123450B7;
        cyc(1'b1, f_go,  "lui_fetch");
        cyc(1'b1, dec_v, "lui_decode");
        cyc(1'b1, v(0,0,0,0,0,0,0,0,0,0,1,4'd10,2'd0,0,0), "lui_exec");
        cyc(1'b1, v(0,0,0,0,0,1,0,0,1,0,1,4'd10,2'd0,1,0), "lui_wb");

        // jal x1, 16
        instr = 32'h010000EF;
        cyc(1'b1, f_go,  "jal_fetch");
        cyc(1'b1, dec_v, "jal_decode");
        cyc(1'b1, v(0,0,0,0,0,0,0,0,0,1,1,4'd0,2'd0,0,0), "jal_exec");
        cyc(1'b1, v(0,0,0,0,0,1,1,0,1,1,1,4'd0,2'd2,1,0), "jal_wb");

        // all-zero IR traps and stays trapped with no memory requests
        instr = 32'h00000000;
        cyc(1'b1, f_go,  "ill0_fetch");
        cyc(1'b1, dec_v, "ill0_decode");
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, v(0,0,0,0,0,0,0,0,0,0,0,4'd0,2'd0,0,1), "ill0_trap");
        end

        // reset out of TRAP
        rst = 1'b1; #1;
        chk("trap_reset", zero_v);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        cyc(1'b1, zero_v, "idle2");

        // sw interrupted by reset while waiting in MEM
        instr = 32'h0020A223;
        cyc(1'b1, f_go,  "sw2_fetch");
        cyc(1'b1, dec_v, "sw2_decode");
        cyc(1'b1, v(0,0,0,0,0,0,0,0,0,0,1,4'd0,2'd0,0,0), "sw2_exec");
        mem_ready = 1'b0; #1;
        chk("sw2_mem_w", v(1,1,1,0,0,0,0,0,0,0,1,4'd0,2'd0,0,0));
        #1 rst = 1'b1; #1;
        chk("sw2_rst_async", zero_v);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        cyc(1'b1, zero_v, "idle3");
        cyc(1'b0, f_wait, "refetch_w");

        // branch funct3 010 is illegal
        instr = 32'h00002463;
        cyc(1'b1, f_go,  "ill_br_fetch");
        cyc(1'b1, dec_v, "ill_br_decode");
        cyc(1'b1, v(0,0,0,0,0,0,0,0,0,0,0,4'd0,2'd0,0,1), "ill_br_trap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
